psram_arb_mc: RTL

Multi-channel PSRAM arbiter that shares one Gowin PSRAM HS controller command port among `NUM_CH` requesters, such as the SPI framebuffer writer, the video framebuffer reader and future DMA/overlay clients. It is the parametrised successor of the two-port read/write arbiter. It adds:
- any channel count;
- selectable fixed-priority or round-robin arbitration;
- a burst-beat sequencer for writes;
- per-channel routing of read data;
- a read-timeout watchdog with sticky error reporting.

It sits between the client blocks and `PSRAM_Memory_Interface_HS_Top`, in the controller's `clk_out` domain.

---
 rtl/psram_arb_mc.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/psram_arb_mc.sv
// Multi-channel arbiter sharing one PSRAM HS controller command port.
// It provides fixed-priority or round-robin grants, write burst beats, read routing and a read timeout.
module psram_arb_mc #(
    parameter int unsigned NUM_CH      = 3,
    parameter int unsigned ADDR_W      = 21,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned MASK_W      = 8,
    parameter int unsigned BURST_BEATS = 4,
    parameter int unsigned CMD_GAP     = 14,
    parameter int unsigned RD_TIMEOUT  = 255,
    parameter int unsigned ARB_MODE    = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_psram_init_calib,
    output logic                       o_psram_cmd_en,
    output logic                       o_psram_cmd,
    output logic [ADDR_W-1:0]          o_psram_addr,
    output logic [DATA_W-1:0]          o_psram_wr_data,
    output logic [MASK_W-1:0]          o_psram_data_mask,
    input  logic [DATA_W-1:0]          i_psram_rd_data,
    input  logic                       i_psram_rd_data_valid,
    input  logic [NUM_CH-1:0]          i_req,
    input  logic [NUM_CH-1:0]          i_we,
    input  logic [NUM_CH*ADDR_W-1:0]   i_addr,
    input  logic [NUM_CH*DATA_W-1:0]   i_wdata,
    input  logic [NUM_CH*MASK_W-1:0]   i_wmask,
    output logic [NUM_CH-1:0]          o_gnt,
    output logic [NUM_CH-1:0]          o_wbeat,
    output logic [DATA_W-1:0]          o_rdata,
    output logic [NUM_CH-1:0]          o_rvalid,
    output logic                       o_busy,
    output logic                       o_err_timeout
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned BEAT_W = $clog2(BURST_BEATS + 1);
    localparam int unsigned GAP_W  = $clog2(CMD_GAP + 1);
    localparam int unsigned TO_W   = $clog2(RD_TIMEOUT + 1);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_WR, S_RD_WAIT, S_RD, S_GAP} state_t;

    state_t              r_state;
    logic [CH_W-1:0]     r_last_w;
    logic [BEAT_W-1:0]   r_beat;
    logic [GAP_W-1:0]    r_gap;
    logic [TO_W-1:0]     r_tcnt;
    logic                r_err;
    logic                r_busy;
    logic [NUM_CH-1:0]   r_rvalid;
    logic [DATA_W-1:0]   r_rdata;

    logic [CH_W-1:0]     w_win;
    logic [CH_W:0]       w_idx;
    logic                w_grant;
    logic [CH_W-1:0]     w_sel;

    // Winner: lowest set index, or first set index after the previous winner.
    always_comb begin
        w_win = '0;
        w_idx = '0;
        if (ARB_MODE == 0) begin
            for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
                if (i_req[CH_W'(i)]) w_win = CH_W'(i);
            end
        end else begin
            for (int k = int'(NUM_CH); k >= 1; k--) begin
                w_idx = (CH_W+1)'(r_last_w) + (CH_W+1)'(k);
                if (w_idx >= (CH_W+1)'(NUM_CH)) w_idx = w_idx - (CH_W+1)'(NUM_CH);
                if (i_req[w_idx[CH_W-1:0]]) w_win = w_idx[CH_W-1:0];
            end
        end
    end

    assign w_grant = (r_state == S_IDLE) && (|i_req);
    assign w_sel   = w_grant ? w_win : r_last_w;

    // Command port is driven straight from the registered state so beat 0 rides with the grant.
    always_comb begin
        o_gnt             = '0;
        o_psram_cmd_en    = 1'b0;
        o_psram_cmd       = 1'b0;
        o_psram_addr      = '0;
        o_psram_wr_data   = '0;
        o_psram_data_mask = '0;
        o_wbeat           = '0;
        if (w_grant) begin
            o_gnt[w_win]   = 1'b1;
            o_psram_cmd_en = 1'b1;
            o_psram_cmd    = i_we[w_win];
            o_psram_addr   = i_addr[w_win*ADDR_W +: ADDR_W];
        end
        if ((w_grant && i_we[w_win]) || (r_state == S_WR)) begin
            o_wbeat[w_sel]    = 1'b1;
            o_psram_wr_data   = i_wdata[w_sel*DATA_W +: DATA_W];
            o_psram_data_mask = i_wmask[w_sel*MASK_W +: MASK_W];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_INIT;
            r_last_w <= CH_W'(NUM_CH - 1);
            r_beat   <= '0;
            r_gap    <= '0;
            r_tcnt   <= '0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_rvalid <= '0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= '0;
            r_busy   <= 1'b1;
            if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
            case (r_state)
                S_INIT: begin
                    if (i_psram_init_calib) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                S_IDLE: begin
                    if (w_grant) begin
                        r_last_w <= w_win;
                        r_gap    <= GAP_W'(CMD_GAP - 1);
                        r_beat   <= BEAT_W'(1);
                        r_tcnt   <= '0;
                        r_state  <= i_we[w_win] ? S_WR : S_RD_WAIT;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_WR: begin
                    if (r_beat == BEAT_W'(BURST_BEATS - 1)) r_state <= S_GAP;
                    else r_beat <= r_beat + BEAT_W'(1);
                end
                // Valid data wins over a timeout that expires in the same cycle.
                S_RD_WAIT: begin
                    if (i_psram_rd_data_valid) begin
                        r_rvalid[r_last_w] <= 1'b1;
                        r_rdata            <= i_psram_rd_data;
                        r_beat             <= BEAT_W'(1);
                        r_state            <= S_RD;
                    end else if (r_tcnt == TO_W'(RD_TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_GAP;
                    end else begin
                        r_tcnt <= r_tcnt + TO_W'(1);
                    end
                end
                S_RD: begin
                    if (i_psram_rd_data_valid) begin
                        r_rvalid[r_last_w] <= 1'b1;
                        r_rdata            <= i_psram_rd_data;
                        if (r_beat == BEAT_W'(BURST_BEATS - 1)) r_state <= S_GAP;
                        else r_beat <= r_beat + BEAT_W'(1);
                    end
                end
                // Leave when the counter is about to hit zero so spacing equals CMD_GAP exactly.
                S_GAP: begin
                    if (r_gap <= GAP_W'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign o_rvalid      = r_rvalid;
    assign o_rdata       = r_rdata;
    assign o_busy        = r_busy;
    assign o_err_timeout = r_err;

endmodule
